// File: rtl/sinc_pkg.sv
// ============================================================================
//  Module      : sinc_pkg
//  Description : Shared definitions for the sequential signed incrementer:
//                FSM state encoding and width-parametrised rail helpers used
//                when saturating arithmetic is built in (SINC_SAT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sinc_pkg;

    // Controller states; the encoding is fixed so external observers and
    // scheduled-datapath tooling can decode it consistently.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sinc_state_t;

    // Widest data width the rail helpers can describe.
    localparam int unsigned SINC_RAIL_W = 64;

    // Largest positive two's complement value of a w-bit signed number,
    // returned zero-extended in a SINC_RAIL_W-bit vector.
    function automatic logic [SINC_RAIL_W-1:0] sinc_max_rail(input int unsigned w);
        logic [SINC_RAIL_W-1:0] one;
        one = {{(SINC_RAIL_W-1){1'b0}}, 1'b1};
        return (one << (w - 1)) - one;
    endfunction

    // Most negative two's complement value of a w-bit signed number; only the
    // low w bits of the result are meaningful.
    function automatic logic [SINC_RAIL_W-1:0] sinc_min_rail(input int unsigned w);
        return ~sinc_max_rail(w);
    endfunction

endpackage : sinc_pkg

`default_nettype wire

// File: rtl/sinc_step.sv
// ============================================================================
//  Module      : sinc_step
//  Description : Combinational signed +/-STEP stage. Computes x +/- STEP at
//                DATAWIDTH+1 bits and flags overflow of the DATAWIDTH range.
//                Macro SINC_SAT_EN: defined -> clamp to max/min rail on
//                overflow; undefined -> wrap modulo 2^DATAWIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sinc_step
    import sinc_pkg::*;
#(
    parameter int          DATAWIDTH = 8,
    parameter int unsigned STEP      = 1
) (
    input  logic [DATAWIDTH-1:0] x,
    input  logic                 dir,
    output logic [DATAWIDTH-1:0] y,
    output logic                 ov
);

    // Step magnitude at the widened internal precision.
    localparam logic [DATAWIDTH:0] STEP_EXT = (DATAWIDTH+1)'(STEP);

`ifdef SINC_SAT_EN
    localparam logic [SINC_RAIL_W-1:0] MAX_FULL = sinc_max_rail(DATAWIDTH);
    localparam logic [SINC_RAIL_W-1:0] MIN_FULL = sinc_min_rail(DATAWIDTH);
    localparam logic [DATAWIDTH-1:0]   MAX_RAIL = MAX_FULL[DATAWIDTH-1:0];
    localparam logic [DATAWIDTH-1:0]   MIN_RAIL = MIN_FULL[DATAWIDTH-1:0];
`endif

    logic [DATAWIDTH:0] x_ext;
    logic [DATAWIDTH:0] sum;

    // One guard bit is enough: |STEP| < 2^(DATAWIDTH-1) keeps the true result
    // inside the DATAWIDTH+1 range, so the top two bits differ only on overflow.
    always_comb begin
        x_ext = {x[DATAWIDTH-1], x};
        sum   = dir ? (x_ext - STEP_EXT) : (x_ext + STEP_EXT);
        ov    = sum[DATAWIDTH] ^ sum[DATAWIDTH-1];
`ifdef SINC_SAT_EN
        if (ov) begin
            y = dir ? MIN_RAIL : MAX_RAIL;
        end else begin
            y = sum[DATAWIDTH-1:0];
        end
`else
        y = sum[DATAWIDTH-1:0];
`endif
    end

endmodule : sinc_step

`default_nettype wire

// File: rtl/sinc_seq_counter.sv
// ============================================================================
//  Module      : sinc_seq_counter
//  Description : Sequential signed index generator. Loads a signed start
//                value on an accepted start, then applies +STEP or -STEP once
//                per clock for len cycles, with busy/done handshake and a
//                sticky overflow flag. Overflow behaviour (wrap vs. saturate)
//                is selected by macro SINC_SAT_EN inside sinc_step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sinc_seq_counter
    import sinc_pkg::*;
#(
    parameter int          DATAWIDTH = 8,
    parameter int          CNTWIDTH  = 4,
    parameter int unsigned STEP      = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic                 dir,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [CNTWIDTH-1:0]  len,
    output logic [DATAWIDTH-1:0] d,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);

    sinc_state_t          state_q, state_d;
    logic [DATAWIDTH-1:0] d_q,     d_d;
    logic [CNTWIDTH-1:0]  rem_q,   rem_d;
    logic                 dir_q,   dir_d;
    logic                 ovf_q,   ovf_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;

    logic [DATAWIDTH-1:0] step_y;
    logic                 step_ov;

    // Arithmetic stage always works on the registered value and latched dir.
    sinc_step #(
        .DATAWIDTH (DATAWIDTH),
        .STEP      (STEP)
    ) u_step (
        .x   (d_q),
        .dir (dir_q),
        .y   (step_y),
        .ov  (step_ov)
    );

    // Next-state and next-output logic; busy/done are computed one cycle
    // ahead so that the outputs come straight from flops.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    d_d     = a;
                    rem_d   = len;
                    dir_d   = dir;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rem_q != '0) begin
                    d_d   = step_y;
                    rem_d = rem_q - CNTWIDTH'(1);
                    if (step_ov) begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any run without a done pulse.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign d    = d_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule : sinc_seq_counter

`default_nettype wire

// File: tb/tb_sinc_seq_counter.sv
// ============================================================================
//  Module      : tb_sinc_seq_counter
//  Description : Scoreboard bench for sinc_seq_counter (8-bit data, 4-bit
//                count, STEP=1). Expected per-cycle outputs are queued when a
//                run is launched; a negedge monitor pops and compares them.
//                Expected values follow SINC_SAT_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sinc_seq_counter;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          Clk   = 1'b0;
    logic          Rst   = 1'b1;
    logic          start = 1'b0;
    logic          dir   = 1'b0;
    logic [DW-1:0] a     = '0;
    logic [CW-1:0] len   = '0;
    logic [DW-1:0] d;
    logic          busy;
    logic          done;
    logic          ovf;

    sinc_seq_counter #(
        .DATAWIDTH (DW),
        .CNTWIDTH  (CW),
        .STEP      (1)
    ) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .start (start),
        .dir   (dir),
        .a     (a),
        .len   (len),
        .d     (d),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          busy;
        logic          done;
        logic          ovf;
        int            tag;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vd[$];
    bit   vo[$];

    // Monitor: one expected entry per cycle while a run is being tracked,
    // otherwise the DUT must sit idle with no done pulse.
    always @(negedge Clk) begin
        if (!Rst) begin
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                n_checks++;
                if (d !== mon_e.d || busy !== mon_e.busy ||
                    done !== mon_e.done || ovf !== mon_e.ovf) begin
                    n_fail++;
                    $display("FAIL run%0d cyc%0d: got d=%0d busy=%0b done=%0b ovf=%0b, expected d=%0d busy=%0b done=%0b ovf=%0b",
                             mon_e.tag, mon_e.cyc, $signed(d), busy, done, ovf,
                             $signed(mon_e.d), mon_e.busy, mon_e.done, mon_e.ovf);
                end
            end else begin
                n_checks++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle: got busy=%0b done=%0b, expected busy=0 done=0", busy, done);
                end
            end
        end
    end

    task automatic push_one(input int tag, input int cyc, input int dv,
                            input bit b, input bit dn, input bit o);
        exp_t e;
        e.d    = DW'(dv);
        e.busy = b;
        e.done = dn;
        e.ovf  = o;
        e.tag  = tag;
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    // Expected trace for cycles T+1 .. T+3+len from the vd/vo tables.
    task automatic push_run(input int tag, input int ln);
        for (int k = 0; k <= ln; k++) push_one(tag, k + 1, vd[k], 1'b1, 1'b0, vo[k]);
        push_one(tag, ln + 2, vd[ln], 1'b1, 1'b1, vo[ln]);
        push_one(tag, ln + 3, vd[ln], 1'b0, 1'b0, vo[ln]);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge Clk);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain timeout: got %0d pending entries, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Launch one run; inputs are scrambled after acceptance and an optional
    // second start is pulsed mid-run, neither of which may disturb it.
    task automatic run(input int tag, input int av, input int ln,
                       input bit dv, input bit inject);
        @(posedge Clk);
        #1;
        start = 1'b1;
        a     = DW'(av);
        len   = CW'(ln);
        dir   = dv;
        @(posedge Clk);
        #1;
        start = 1'b0;
        a     = 8'h55;
        len   = 4'hF;
        dir   = ~dv;
        push_run(tag, ln);
        if (inject) begin
            @(posedge Clk);
            #1;
            start = 1'b1;
            a     = 8'd99;
            len   = 4'd7;
            dir   = 1'b1;
            @(posedge Clk);
            #1;
            start = 1'b0;
        end
        drain();
    endtask

    initial begin
        #12;
        n_checks++;
        if (d !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got d=%0d busy=%0b done=%0b ovf=%0b, expected all 0", d, busy, done, ovf);
        end
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        repeat (2) @(posedge Clk);

        // Plain increment
        vd = '{20, 21, 22, 23};
        vo = '{0, 0, 0, 0};
        run(1, 20, 3, 1'b0, 1'b0);

        // Plain decrement into negatives
        vd = '{-7, -8, -9};
        vo = '{0, 0, 0};
        run(2, -7, 2, 1'b1, 1'b0);

        // Positive overflow
`ifdef SINC_SAT_EN
        vd = '{125, 126, 127, 127, 127, 127};
`else
        vd = '{125, 126, 127, -128, -127, -126};
`endif
        vo = '{0, 0, 0, 1, 1, 1};
        run(3, 125, 5, 1'b0, 1'b0);

        // Zero-length run; also shows ovf cleared by the new start
        vd = '{25};
        vo = '{0};
        run(4, 25, 0, 1'b0, 1'b0);

        // Start pulsed during a run is ignored
        vd = '{20, 21, 22, 23};
        vo = '{0, 0, 0, 0};
        run(5, 20, 3, 1'b0, 1'b1);

        // Negative overflow
`ifdef SINC_SAT_EN
        vd = '{-127, -128, -128, -128};
`else
        vd = '{-127, -128, 127, 126};
`endif
        vo = '{0, 0, 1, 1};
        run(6, -127, 3, 1'b1, 1'b0);

        // Maximum length crossing zero
        vd.delete();
        vo.delete();
        for (int k = 0; k <= 15; k++) begin
            vd.push_back(k - 1);
            vo.push_back(1'b0);
        end
        run(7, -1, 15, 1'b0, 1'b0);

        // Reset in the middle of a len=5 run, after ovf has been raised
        @(posedge Clk);
        #1;
        start = 1'b1;
        a     = 8'd127;
        len   = 4'd5;
        dir   = 1'b0;
        @(posedge Clk);
        #1;
        start = 1'b0;
        push_one(8, 1, 127, 1'b1, 1'b0, 1'b0);
`ifdef SINC_SAT_EN
        push_one(8, 2, 127, 1'b1, 1'b0, 1'b1);
`else
        push_one(8, 2, -128, 1'b1, 1'b0, 1'b1);
`endif
        @(negedge Clk);
        @(negedge Clk);
        #2;
        Rst = 1'b1;
        #1;
        n_checks++;
        if (d !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL mid-run reset: got d=%0d busy=%0b done=%0b ovf=%0b, expected all 0", d, busy, done, ovf);
        end
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        repeat (4) @(posedge Clk);

        // Normal operation after the abort
        vd = '{20, 21, 22, 23};
        vo = '{0, 0, 0, 0};
        run(9, 20, 3, 1'b0, 1'b0);

        repeat (2) @(posedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sinc_seq_counter

`default_nettype wire
